// File: rtl/cnn_layer_accel_weight_seq_addr_gen.sv
// rtl/cnn_layer_accel_weight_seq_addr_gen.sv - weight sequence table read sequencer
// Multi-pass repeat and the cfg_num_passes port exist only with WHT_SEQ_ADDR_GEN_REPEAT_EN.
`ifndef NUM_WHT_SEQ_VALUES
`define NUM_WHT_SEQ_VALUES 8
`endif

module cnn_layer_accel_weight_seq_addr_gen #(
   parameter int C_RDADDR_WIDTH = $clog2(`NUM_WHT_SEQ_VALUES),
   parameter int C_LEN_WIDTH    = C_RDADDR_WIDTH + 1,
   parameter int C_PASS_WIDTH   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      stall,
   input  logic [C_LEN_WIDTH-1:0]    cfg_seq_len,
`ifdef WHT_SEQ_ADDR_GEN_REPEAT_EN
   input  logic [C_PASS_WIDTH-1:0]   cfg_num_passes,
`endif
   output logic [C_RDADDR_WIDTH-1:0] rdAddr,
   output logic                      rden,
   output logic                      seq_valid,
   output logic                      seq_last,
   output logic                      busy,
   output logic                      done
);

   localparam logic [C_LEN_WIDTH-1:0] C_MAX_LEN = C_LEN_WIDTH'(`NUM_WHT_SEQ_VALUES);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                      state;
   logic [C_LEN_WIDTH-1:0]      start_len;
   logic [C_RDADDR_WIDTH-1:0]   start_len_m1;
   logic [C_RDADDR_WIDTH-1:0]   len_m1;
   logic [C_RDADDR_WIDTH-1:0]   idx;
   logic                        idx_end;
   logic                        pass_end;
   logic                        start_pass_end;
   // set while the read presented this cycle is the final entry of the final pass
   logic                        last_rd;

   assign start_len    = (cfg_seq_len > C_MAX_LEN) ? C_MAX_LEN : cfg_seq_len;
   assign start_len_m1 = C_RDADDR_WIDTH'(start_len - 1'b1);
   assign idx_end      = (idx == len_m1);

`ifdef WHT_SEQ_ADDR_GEN_REPEAT_EN
   logic [C_PASS_WIDTH-1:0] pass;
   logic [C_PASS_WIDTH-1:0] pass_last;
   logic [C_PASS_WIDTH-1:0] start_pass_last;

   assign start_pass_last = (cfg_num_passes == '0) ? '0 : cfg_num_passes - 1'b1;
   assign start_pass_end  = (start_pass_last == '0);
   assign pass_end        = (pass == pass_last);
`else
   assign start_pass_end  = 1'b1;
   assign pass_end        = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         len_m1    <= '0;
         last_rd   <= 1'b0;
         rdAddr    <= '0;
         rden      <= 1'b0;
         seq_valid <= 1'b0;
         seq_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef WHT_SEQ_ADDR_GEN_REPEAT_EN
         pass      <= '0;
         pass_last <= '0;
`endif
      end else begin
         seq_valid <= rden;
         seq_last  <= rden & last_rd;
         done      <= 1'b0;
         if (abort) begin
            state   <= IDLE;
            rden    <= 1'b0;
            busy    <= 1'b0;
            last_rd <= 1'b0;
            idx     <= '0;
`ifdef WHT_SEQ_ADDR_GEN_REPEAT_EN
            pass    <= '0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     busy <= 1'b1;
`ifdef WHT_SEQ_ADDR_GEN_REPEAT_EN
                     pass_last <= start_pass_last;
                     pass      <= (start_len_m1 == '0 && !start_pass_end) ? C_PASS_WIDTH'(1) : '0;
`endif
                     if (start_len == '0) begin
                        state <= DRAIN;
                        done  <= 1'b1;
                     end else begin
                        // entry 0 is issued on the accepting edge so it appears the next cycle
                        state   <= RUN;
                        rden    <= 1'b1;
                        rdAddr  <= '0;
                        len_m1  <= start_len_m1;
                        last_rd <= (start_len_m1 == '0) && start_pass_end;
                        idx     <= (start_len_m1 == '0) ? '0 : C_RDADDR_WIDTH'(1);
                     end
                  end
               end
               RUN: begin
                  if (last_rd) begin
                     state   <= DRAIN;
                     rden    <= 1'b0;
                     last_rd <= 1'b0;
                     done    <= 1'b1;
                  end else if (stall) begin
                     rden   <= 1'b0;
                     rdAddr <= idx;
                  end else begin
                     rden    <= 1'b1;
                     rdAddr  <= idx;
                     last_rd <= idx_end && pass_end;
                     idx     <= idx_end ? '0 : idx + 1'b1;
`ifdef WHT_SEQ_ADDR_GEN_REPEAT_EN
                     if (idx_end && !pass_end) pass <= pass + 1'b1;
`endif
                  end
               end
               DRAIN: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
